matmul_core: RTL and testbench
==============================

# matmul_core

Fixed-size square matrix multiplier: computes outmat = mat1 × mat2 for two M×M signed matrices presented as parallel array ports. It starts automatically when reset is released, produces one output element per clock in row-major order, then holds the result. It sits as a standalone compute block; the surrounding logic holds the operands stable and samples outmat after done.

## Interface
- DATA_WIDTH, 16: signed operand width.
- M, 32: matrix dimension (M×M); M ≥ 2.
- ACC_W (derived, not overridable): 2*DATA_WIDTH + $clog2(M) = 37.
- clk  in  1  rising-edge clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- mat1  in  [M-1:0][M-1:0] × ACC_W  left operand, element [row][col].
- mat2  in  [M-1:0][M-1:0] × ACC_W  right operand, element [row][col].
- outmat  out  [M-1:0][M-1:0] × ACC_W  signed product matrix, registered.
- done  out  1  high when all M*M elements are written; registered.

## Operation
- Element type: signed ACC_W bits. Only the low DATA_WIDTH bits of each input element are used, interpreted as signed; the upper bits are ignored.
- outmat[i][j] = Σ_{k=0..M-1} mat1[i][k]·mat2[k][j].
  - Each product is a full signed 2*DATA_WIDTH result, sign-extended to ACC_W.
  - The sum is exact; no overflow is possible.
- FSM states:
  - RUN: entered on reset release. Row counter i and column counter j start at 0.
  - Each RUN cycle writes outmat[i][j]. j increments; on wrap from M-1 to 0, i increments.
  - When i = j = M-1 is written, go to DONE.
  - DONE: outmat holds and done = 1 until the next reset. No restart without reset.
- Inputs are read live, not captured. The operands must stay stable from reset release until done. Elements already written are not updated if the inputs change.
- Unused or smaller effective dimensions: the caller zero-fills. The block always computes the full M×M product.

## Timing
- While reset = 0: outmat = all zeros, done = 0, i = j = 0, state = RUN. All are cleared asynchronously.
- After reset release, edge n (n = 1..M*M) writes element n-1 in row-major order.
  - The first element is written at the first rising edge after release.
  - done rises on the same edge as the final write, edge M*M (1024 for the defaults).
- Throughput: one dot product (M multiplies plus an adder tree) per cycle, combinational between input ports and outmat.
  - An optional single pipeline register is permitted, which delays each write and done by exactly 1 cycle.
  - Total latency must not exceed M*M + 4 cycles.
- Reset mid-operation: immediate clear of outmat, done and the counters; the computation restarts from [0][0] after release.

## Structure
- Package matmul_pkg holds DATA_WIDTH, M, ACC_W and typedef mat_elem (logic signed [ACC_W-1:0]). The bench and RTL share it.
- Sub-module dot_product: inputs are M row elements and M column elements; output is an ACC_W signed sum built from M signed multipliers and a balanced adder tree. The top module owns the FSM, counters, row/column muxing and the outmat register array.

## Test plan
- Reset: hold reset = 0 for several cycles -> outmat all 0, done = 0. Release -> outmat[0][0] valid after edge 1, done = 1 at edge 1024.
- Identity: mat1 = I, mat2 = random 0..3 -> outmat = mat2 exactly. All-zero mat1 -> outmat all 0.
- Random values in 0..3 (row max sum 288) -> element-wise match with the software reference for all 1024 elements after 1250 cycles.
- Signed extremes:
  - mat1 = mat2 = all -32768 -> every element = 34359738368.
  - mat1 = all 32767, mat2 = all -32768 -> every element = -34358689792.
- Upper-bit masking: inputs 0x1_0000_0003 and 2 everywhere -> every element = 192.
- Mid-run reset: assert reset at cycle 500 -> outmat cleared at once. Release, then run a new operand set -> correct result at cycle 1024 with no stale elements.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared widths, element type and FSM states for the matrix multiplier.
//   DATA_WIDTH - signed operand width actually used from each input element
//   M          - matrix dimension (M x M)
//   ACC_W      - element width, wide enough for an exact M-term dot product
package matmul_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int M          = 32;
   localparam int ACC_W      = 2 * DATA_WIDTH + $clog2(M);
   localparam int IDX_W      = $clog2(M);
   typedef logic signed [ACC_W-1:0] mat_elem;
   typedef enum logic {RUN, DONE} state_e;
endpackage

// File: rtl/matmul_core_if.sv
// matmul_core_if: operand/result bundle of the matrix multiplier.
//   mat1, mat2 - operand matrices, element [row][col]
//   outmat     - registered product matrix
//   done       - high once every element of outmat is written
interface matmul_core_if;
   import matmul_pkg::*;
   mat_elem mat1   [M-1:0][M-1:0];
   mat_elem mat2   [M-1:0][M-1:0];
   mat_elem outmat [M-1:0][M-1:0];
   logic    done;
   modport master (output mat1, mat2, input outmat, done);
   modport slave  (input mat1, mat2, output outmat, done);
endinterface

// File: rtl/dot_product.sv
// dot_product: combinational signed dot product of one row and one column.
//   i_row - M row elements (low DATA_WIDTH bits used, signed)
//   i_col - M column elements (low DATA_WIDTH bits used, signed)
//   o_sum - exact ACC_W signed sum of the M products
module dot_product
   import matmul_pkg::*;
(
   input  mat_elem i_row [M],
   input  mat_elem i_col [M],
   output mat_elem o_sum
);
   localparam int L = $clog2(M);
   localparam int P = 1 << L;
   logic w_unused;
   // Upper element bits are ignored by definition; fold them away explicitly.
   always_comb begin
      w_unused = 1'b0;
      for (int n = 0; n < M; n++)
         w_unused = w_unused ^ (^{i_row[n][ACC_W-1:DATA_WIDTH], i_col[n][ACC_W-1:DATA_WIDTH]});
   end
   // Level 0 holds the products (zero-padded to a power of two); each further
   // level halves the node count, so level L is the root of a balanced tree.
   genvar l, k;
   for (l = 0; l <= L; l++) begin : g_lvl
      mat_elem w_s [P >> l];
      for (k = 0; k < (P >> l); k++) begin : g_node
         if (l == 0 && k < M) begin : g_mul
            logic signed [2*DATA_WIDTH-1:0] w_prod;
            assign w_prod = $signed(i_row[k][DATA_WIDTH-1:0]) * $signed(i_col[k][DATA_WIDTH-1:0]);
            assign w_s[k] = mat_elem'(w_prod);
         end else if (l == 0) begin : g_pad
            assign w_s[k] = '0;
         end else begin : g_add
            assign w_s[k] = g_lvl[l-1].w_s[2*k] + g_lvl[l-1].w_s[2*k+1];
         end
      end
   end
   assign o_sum = g_lvl[L].w_s[0];
endmodule

// File: rtl/matmul_core.sv
// matmul_core: M x M signed matrix multiplier, one output element per clock in row-major order.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset; release starts the computation
//   bus   - slave side of matmul_core_if (mat1, mat2 in; outmat, done out)
module matmul_core
   import matmul_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   matmul_core_if.slave bus
);
   state_e           r_state;
   logic [IDX_W-1:0] r_i;
   logic [IDX_W-1:0] r_j;
   logic             r_done;
   mat_elem          r_out [M-1:0][M-1:0];
   mat_elem          w_row [M];
   mat_elem          w_col [M];
   mat_elem          w_sum;
   logic             w_row_end;
   genvar k;
   for (k = 0; k < M; k++) begin : g_sel
      assign w_row[k] = bus.mat1[r_i][k];
      assign w_col[k] = bus.mat2[k][r_j];
   end
   dot_product u_dot (
      .i_row (w_row),
      .i_col (w_col),
      .o_sum (w_sum)
   );
   assign w_row_end = r_j == IDX_W'(M - 1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
         r_i     <= '0;
         r_j     <= '0;
         r_done  <= 1'b0;
         for (int a = 0; a < M; a++)
            for (int b = 0; b < M; b++)
               r_out[a][b] <= '0;
      end else if (r_state == RUN) begin
         r_out[r_i][r_j] <= w_sum;
         r_j <= w_row_end ? '0 : r_j + 1'b1;
         r_i <= w_row_end ? r_i + 1'b1 : r_i;
         if (w_row_end && r_i == IDX_W'(M - 1)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
         end
      end
   end
   assign bus.outmat = r_out;
   assign bus.done   = r_done;
endmodule

// File: tb/tb_matmul_core.sv
// tb_matmul_core: directed and randomized checks of matmul_core against a plain-arithmetic reference.
module tb_matmul_core;
   import matmul_pkg::*;
   logic    clk   = 1'b0;
   logic    reset = 1'b0;
   int      checks = 0;
   int      errors = 0;
   mat_elem a [M][M];
   mat_elem b [M][M];
   longint  exp_m [M][M];

   matmul_core_if bus ();
   matmul_core dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   function automatic longint lo(input mat_elem x);
      logic signed [DATA_WIDTH-1:0] t;
      t = x[DATA_WIDTH-1:0];
      return longint'(t);
   endfunction

   function automatic mat_elem rnd_full();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[ACC_W-1:0];
   endfunction

   task automatic set_ops(input int mode);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) begin
            if (mode == 0) begin
               a[i][j] = (i == j) ? mat_elem'(1) : mat_elem'(0);
               b[i][j] = mat_elem'($urandom_range(3));
            end else if (mode == 1) begin
               a[i][j] = '0;
               b[i][j] = mat_elem'($urandom_range(3));
            end else if (mode == 2) begin
               a[i][j] = mat_elem'($urandom_range(3));
               b[i][j] = mat_elem'($urandom_range(3));
            end else if (mode == 3) begin
               a[i][j] = mat_elem'(-32768);
               b[i][j] = mat_elem'(-32768);
            end else if (mode == 4) begin
               a[i][j] = mat_elem'(32767);
               b[i][j] = mat_elem'(-32768);
            end else if (mode == 5) begin
               a[i][j] = 37'h1_0000_0003;
               b[i][j] = mat_elem'(2);
            end else begin
               a[i][j] = rnd_full();
               b[i][j] = rnd_full();
            end
            bus.mat1[i][j] = a[i][j];
            bus.mat2[i][j] = b[i][j];
         end
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) begin
            longint s = 0;
            for (int n = 0; n < M; n++) s += lo(a[i][n]) * lo(b[n][j]);
            exp_m[i][j] = s;
         end
   endtask

   task automatic check(input string tag, input mat_elem obs, input mat_elem expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic cmp_all(input string tag, input bit zero);
      int      bad = 0;
      int      fi = 0, fj = 0;
      mat_elem fo = '0, fe = '0;
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) begin
            mat_elem e;
            e = zero ? '0 : mat_elem'(exp_m[i][j]);
            if (bus.outmat[i][j] !== e) begin
               if (bad == 0) begin
                  fi = i; fj = j; fo = bus.outmat[i][j]; fe = e;
               end
               bad++;
            end
         end
      checks++;
      assert (bad == 0) else begin
         errors++;
         $error("FAIL %s %0d bad elements, first [%0d][%0d] observed=%0d expected=%0d",
                tag, bad, fi, fj, fo, fe);
      end
   endtask

   task automatic do_run(input string tag, input int mode);
      reset = 1'b0;
      set_ops(mode);
      repeat (3) @(negedge clk);
      cmp_all({tag, "_rst_zero"}, 1'b1);
      check({tag, "_rst_done"}, mat_elem'(bus.done), '0);
      reset = 1'b1;
      for (int n = 1; n <= M * M; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) begin
            check({tag, "_first"}, bus.outmat[0][0], mat_elem'(exp_m[0][0]));
            check({tag, "_second_unwritten"}, bus.outmat[0][1], '0);
         end
         if (n == M * M - 1) check({tag, "_done_early"}, mat_elem'(bus.done), '0);
      end
      check({tag, "_done"}, mat_elem'(bus.done), mat_elem'(1));
      cmp_all(tag, 1'b0);
   endtask

   initial begin
      do_run("identity", 0);
      for (int i = 0; i < M; i++)
         for (int j = 0; j < M; j++) begin
            bus.mat1[i][j] = '0;
            bus.mat2[i][j] = rnd_full();
         end
      repeat (5) @(posedge clk);
      #1;
      cmp_all("hold_after_done", 1'b0);
      check("hold_done", mat_elem'(bus.done), mat_elem'(1));

      do_run("zero", 1);
      do_run("rand03", 2);
      do_run("neg_neg", 3);
      check("neg_neg_lit", bus.outmat[3][17], 37'sd34359738368);
      do_run("pos_neg", 4);
      check("pos_neg_lit", bus.outmat[30][2], -37'sd34358689792);
      do_run("mask", 5);
      check("mask_lit", bus.outmat[9][31], mat_elem'(192));

      reset = 1'b0;
      set_ops(2);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (500) @(posedge clk);
      #1;
      check("mid_pre_first", bus.outmat[0][0], mat_elem'(exp_m[0][0]));
      check("mid_pre_last", bus.outmat[15][19], mat_elem'(exp_m[15][19]));
      check("mid_pre_next", bus.outmat[15][20], '0);
      reset = 1'b0;
      #1;
      cmp_all("mid_reset_clear", 1'b1);
      check("mid_reset_done", mat_elem'(bus.done), '0);
      do_run("after_mid", 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
